// File: rtl/wb_gpio_bank.sv
// wb_gpio_bank
// Wishbone-mapped GPIO bank. Each pad has an output value, an active-low output
// enable and a synchronised input. Optional edge-detect interrupts can be
// configured per pad to fire on a rising or a falling edge.
// Build option: define GPIO_IRQ_EN to include the edge detector, the warm-up
// counter and the IRQ_EN / IRQ_STAT / EDGE_SEL registers. Without it, those
// offsets are still acked but read 0, and irq is tied low.

module wb_gpio_bank #(
  parameter int unsigned NPADS    = 16,
  parameter logic [31:0] BASE_ADR = 32'h3000_0000
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic             wbs_cyc_i,
  input  logic             wbs_stb_i,
  input  logic             wbs_we_i,
  input  logic [3:0]       wbs_sel_i,
  input  logic [31:0]      wbs_adr_i,
  input  logic [31:0]      wbs_dat_i,
  output logic             wbs_ack_o,
  output logic [31:0]      wbs_dat_o,
  input  logic [NPADS-1:0] io_in,
  output logic [NPADS-1:0] io_out,
  output logic [NPADS-1:0] io_oeb,
  output logic             irq
);

  localparam logic [7:0] OFS_OUT  = 8'h00;
  localparam logic [7:0] OFS_OEB  = 8'h04;
  localparam logic [7:0] OFS_IN   = 8'h08;
  localparam logic [7:0] OFS_IEN  = 8'h0C;
  localparam logic [7:0] OFS_STAT = 8'h10;
  localparam logic [7:0] OFS_ESEL = 8'h14;

  logic [7:0]       offset;
  logic             winHit;
  logic             req;
  logic             wrEn;
  logic [31:0]      laneMask;
  logic [NPADS-1:0] wrMask;
  logic [NPADS-1:0] wrBits;
  logic [31:0]      rdData;

  logic             ack_q, ack_d;
  logic [31:0]      dat_q, dat_d;
  logic [NPADS-1:0] out_q, out_d;
  logic [NPADS-1:0] oeb_q, oeb_d;
  logic [NPADS-1:0] s1_q, s2_q;

  // A request is only taken when no ack is outstanding, so every transfer
  // occupies two cycles and ack never stays high for more than one.
  assign offset   = wbs_adr_i[7:0];
  assign winHit   = (wbs_adr_i[31:8] == BASE_ADR[31:8]);
  assign req      = wbs_cyc_i & wbs_stb_i & winHit & ~ack_q;
  assign wrEn     = req & wbs_we_i;
  assign laneMask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}},
                     {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
  assign wrMask   = laneMask[NPADS-1:0];
  assign wrBits   = wbs_dat_i[NPADS-1:0];

  // Data and lane bits above the last pad are intentionally ignored.
  logic unusedBits;
  assign unusedBits = ^{wbs_dat_i, laneMask};

  function automatic logic [NPADS-1:0] mergeBytes(input logic [NPADS-1:0] cur,
                                                  input logic [NPADS-1:0] mask,
                                                  input logic [NPADS-1:0] val);
    return (cur & ~mask) | (val & mask);
  endfunction

  // Two-flop synchroniser for the asynchronous pad inputs; s2 is the IN value.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= io_in;
      s2_q <= s1_q;
    end
  end

`ifdef GPIO_IRQ_EN
  logic [NPADS-1:0] s3_q;
  logic [NPADS-1:0] ien_q, ien_d;
  logic [NPADS-1:0] stat_q, stat_d;
  logic [NPADS-1:0] esel_q, esel_d;
  logic [1:0]       warm_q, warm_d;
  logic [NPADS-1:0] riseEv, fallEv, edgeEv, clrBits;

  // Edge detection and interrupt register updates. A new edge beats a
  // simultaneous write-one-to-clear on the same bit. Edges are ignored until
  // the warm-up counter saturates so the sync chain filling is not seen as
  // an edge.
  always_comb begin
    ien_d   = ien_q;
    esel_d  = esel_q;
    warm_d  = warm_q;
    riseEv  = s2_q & ~s3_q;
    fallEv  = ~s2_q & s3_q;
    edgeEv  = '0;
    clrBits = '0;
    if (warm_q != 2'd3) begin
      warm_d = warm_q + 2'd1;
    end else begin
      edgeEv = (riseEv & esel_q) | (fallEv & ~esel_q);
    end
    if (wrEn && (offset == OFS_STAT)) begin
      clrBits = wrBits & wrMask;
    end
    if (wrEn && (offset == OFS_IEN)) begin
      ien_d = mergeBytes(ien_q, wrMask, wrBits);
    end
    if (wrEn && (offset == OFS_ESEL)) begin
      esel_d = mergeBytes(esel_q, wrMask, wrBits);
    end
    stat_d = (stat_q & ~clrBits) | edgeEv;
  end

  // Interrupt state registers; edge select defaults to rising on every pad.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      s3_q   <= '0;
      ien_q  <= '0;
      stat_q <= '0;
      esel_q <= '1;
      warm_q <= 2'd0;
    end else begin
      s3_q   <= s2_q;
      ien_q  <= ien_d;
      stat_q <= stat_d;
      esel_q <= esel_d;
      warm_q <= warm_d;
    end
  end

  assign irq = |(stat_q & ien_q);
`else
  assign irq = 1'b0;
`endif

  // Read mux: full word regardless of byte enables, zero above the last pad
  // and for any unmapped offset.
  always_comb begin
    rdData = '0;
    case (offset)
      OFS_OUT:  rdData[NPADS-1:0] = out_q;
      OFS_OEB:  rdData[NPADS-1:0] = oeb_q;
      OFS_IN:   rdData[NPADS-1:0] = s2_q;
`ifdef GPIO_IRQ_EN
      OFS_IEN:  rdData[NPADS-1:0] = ien_q;
      OFS_STAT: rdData[NPADS-1:0] = stat_q;
      OFS_ESEL: rdData[NPADS-1:0] = esel_q;
`endif
      default:  rdData = '0;
    endcase
  end

  // Bus handshake and pad output registers: ack and read data are loaded on
  // the request edge and ack falls on the next edge unconditionally.
  always_comb begin
    ack_d = req;
    dat_d = dat_q;
    out_d = out_q;
    oeb_d = oeb_q;
    if (req) begin
      dat_d = rdData;
    end
    if (wrEn && (offset == OFS_OUT)) begin
      out_d = mergeBytes(out_q, wrMask, wrBits);
    end
    if (wrEn && (offset == OFS_OEB)) begin
      oeb_d = mergeBytes(oeb_q, wrMask, wrBits);
    end
  end

  // Bus-side state; all pads come out of reset as inputs.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      out_q <= '0;
      oeb_q <= '1;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      out_q <= out_d;
      oeb_q <= oeb_d;
    end
  end

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = dat_q;
  assign io_out    = out_q;
  assign io_oeb    = oeb_q;

endmodule

// File: tb/tb_wb_gpio_bank.sv
// Testbench for wb_gpio_bank: directed register/interrupt scenarios followed by
// randomized bus and pad activity, all checked against a behavioural model.

module tb_wb_gpio_bank;

`ifdef GPIO_IRQ_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif
  localparam int          NP      = 16;
  localparam logic [31:0] PADMASK = 32'h0000_FFFF;
  localparam logic [31:0] BASE    = 32'h3000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  sel = 4'h0;
  logic [31:0] adr = 32'h0;
  logic [31:0] datIn = 32'h0;
  logic [15:0] padIn = 16'h0008;
  logic        ackO;
  logic [31:0] datO;
  logic [15:0] ioOut;
  logic [15:0] ioOeb;
  logic        irqO;

  int nVectors = 0;
  int nFail = 0;

  wb_gpio_bank #(.NPADS(NP), .BASE_ADR(BASE)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wbs_cyc_i(cyc),
    .wbs_stb_i(stb),
    .wbs_we_i (we),
    .wbs_sel_i(sel),
    .wbs_adr_i(adr),
    .wbs_dat_i(datIn),
    .wbs_ack_o(ackO),
    .wbs_dat_o(datO),
    .io_in    (padIn),
    .io_out   (ioOut),
    .io_oeb   (ioOeb),
    .irq      (irqO)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVectors++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus a short history of pad samples
  // taken since reset. IN is the sample from two edges back; an edge is a
  // difference between the samples two and three edges back, and only counts
  // once three post-reset samples exist.
  logic [31:0] mOut, mOeb, mIen, mStat, mEsel, mDat;
  bit          mAck = 1'b0;
  bit          mDatValid = 1'b0;
  bit          modelReady = 1'b0;
  logic [31:0] padHist[$];
  logic [31:0] tRd, tSet, tM, tClr, tNew, tOld;
  bit          tReq;

  function automatic logic [31:0] laneBits(input logic [3:0] s);
    logic [31:0] r;
    r = 32'h0;
    for (int b = 0; b < 4; b++) begin
      if (s[b]) r[b*8 +: 8] = 8'hFF;
    end
    return r;
  endfunction

  function automatic logic [31:0] modelRead(input logic [7:0] ofs);
    case (ofs)
      8'h00: return mOut;
      8'h04: return mOeb;
      8'h08: return (padHist.size() >= 2) ? padHist[$-1] : 32'h0;
      8'h0C: return IRQ_ON ? mIen : 32'h0;
      8'h10: return IRQ_ON ? mStat : 32'h0;
      8'h14: return IRQ_ON ? mEsel : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mOut = 32'h0; mOeb = PADMASK; mIen = 32'h0; mStat = 32'h0;
      mEsel = PADMASK; mDat = 32'h0; mAck = 1'b0; mDatValid = 1'b1;
      padHist.delete();
      modelReady = 1'b1;
    end else if (modelReady) begin
      tReq = cyc && stb && (adr[31:8] == 24'h300000) && !mAck;
      tRd  = modelRead(adr[7:0]);
      tSet = 32'h0;
      if (IRQ_ON && padHist.size() >= 3) begin
        tNew = padHist[$-1];
        tOld = padHist[$-2];
        tSet = ((tNew & ~tOld & mEsel) | (~tNew & tOld & ~mEsel)) & PADMASK;
      end
      tM   = laneBits(sel) & PADMASK;
      tClr = 32'h0;
      if (tReq && we) begin
        case (adr[7:0])
          8'h00: mOut = (mOut & ~tM) | (datIn & tM);
          8'h04: mOeb = (mOeb & ~tM) | (datIn & tM);
          8'h0C: if (IRQ_ON) mIen = (mIen & ~tM) | (datIn & tM);
          8'h10: tClr = datIn & tM;
          8'h14: if (IRQ_ON) mEsel = (mEsel & ~tM) | (datIn & tM);
          default: ;
        endcase
      end
      mStat = (mStat & ~tClr) | tSet;
      mAck  = tReq;
      if (tReq) begin
        mDat = tRd;
        mDatValid = !we;
      end
      padHist.push_back(32'(padIn) & PADMASK);
      if (padHist.size() > 4) void'(padHist.pop_front());
    end
  end

  // Cycle-by-cycle comparison against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (modelReady) begin
      checkOutput("ack", 32'(ackO), 32'(mAck));
      checkOutput("io_out", 32'(ioOut), mOut);
      checkOutput("io_oeb", 32'(ioOeb), mOeb);
      checkOutput("irq", 32'(irqO), 32'(|(mStat & mIen)));
      if (mDatValid) checkOutput("rdata", datO, mDat);
    end
  end

  // One Wishbone transfer; lat is the number of edges until ack (0 = none in 16).
  task automatic busXfer(input bit isWrite, input logic [31:0] a, input logic [3:0] s,
                         input logic [31:0] d, output logic [31:0] rdat, output int lat);
    if (ackO) begin
      @(posedge clk); #1;
    end
    cyc = 1'b1; stb = 1'b1; we = isWrite; adr = a; sel = s; datIn = d;
    lat = 0;
    rdat = 32'h0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      if (ackO === 1'b1) begin
        lat = i;
        rdat = datO;
        break;
      end
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic writeReg(input logic [7:0] ofs, input logic [3:0] s, input logic [31:0] d);
    logic [31:0] rd;
    int lat;
    busXfer(1'b1, BASE | 32'(ofs), s, d, rd, lat);
    checkOutput("write ack latency", 32'(lat), 32'd1);
  endtask

  task automatic readReg(input logic [7:0] ofs, input string nm, input logic [31:0] exp);
    logic [31:0] rd;
    int lat;
    busXfer(1'b0, BASE | 32'(ofs), 4'h0, 32'h0, rd, lat);
    checkOutput("read ack latency", 32'(lat), 32'd1);
    checkOutput(nm, rd, exp);
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  function automatic logic [31:0] pickAdr();
    case ($urandom_range(0, 11))
      0:  return BASE | 32'h00;
      1:  return BASE | 32'h04;
      2:  return BASE | 32'h08;
      3:  return BASE | 32'h0C;
      4:  return BASE | 32'h10;
      5:  return BASE | 32'h14;
      6:  return BASE | 32'h18;
      7:  return BASE | 32'h40;
      8:  return BASE | 32'h10;
      9:  return BASE | 32'h14;
      10: return 32'h3000_0100;
      default: return 32'h2FFF_FF04;
    endcase
  endfunction

  // One randomized cycle of bus and pad activity, with occasional resets and
  // requests held through their ack cycle.
  task automatic applyStimulus();
    rst = ($urandom_range(0, 299) == 0) || (rst && ($urandom_range(0, 1) == 0));
    if ($urandom_range(0, 3) != 0) begin
      cyc   = ($urandom_range(0, 3) != 0);
      stb   = ($urandom_range(0, 3) != 0);
      we    = ($urandom_range(0, 1) != 0);
      sel   = 4'($urandom);
      datIn = $urandom;
      adr   = pickAdr();
    end
    if ($urandom_range(0, 5) == 0) begin
      padIn = padIn ^ 16'(32'd1 << $urandom_range(0, 15));
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd;
    int lat;

    // Reset with pad 3 already high.
    repeat (4) begin
      @(posedge clk); #1;
      checkOutput("ack in reset", 32'(ackO), 32'd0);
      checkOutput("irq in reset", 32'(irqO), 32'd0);
    end
    rst = 1'b0;

    readReg(8'h00, "OUT reset", 32'h0);
    readReg(8'h04, "OEB reset", 32'h0000_FFFF);
    readReg(8'h0C, "IRQ_EN reset", 32'h0);
    readReg(8'h10, "IRQ_STAT reset", 32'h0);
    readReg(8'h14, "EDGE_SEL reset", IRQ_ON ? 32'h0000_FFFF : 32'h0);

    // Warm-up must hide the pad that was high across reset release.
    writeReg(8'h0C, 4'hF, 32'h0000_FFFF);
    readReg(8'h0C, "IRQ_EN readback", IRQ_ON ? 32'h0000_FFFF : 32'h0);
    readReg(8'h10, "IRQ_STAT after warm-up", 32'h0);
    readReg(8'h08, "IN pad3", 32'h0000_0008);

    // Byte lanes and pad outputs.
    writeReg(8'h00, 4'b0001, 32'h0000_A5A5);
    writeReg(8'h04, 4'hF, 32'h0);
    readReg(8'h00, "OUT lane0", 32'h0000_00A5);
    checkOutput("io_out lane0", 32'(ioOut), 32'h0000_00A5);
    checkOutput("io_oeb cleared", 32'(ioOeb), 32'h0);
    writeReg(8'h00, 4'hF, 32'hFFFF_005A);
    readReg(8'h00, "OUT upper bits", 32'h0000_005A);

    // Falling-edge interrupt on pad 5.
    writeReg(8'h0C, 4'hF, 32'h0000_0020);
    writeReg(8'h14, 4'hF, 32'h0000_FFDF);
    padIn[5] = 1'b1;
    waitCycles(6);
    readReg(8'h10, "IRQ_STAT rise unselected", 32'h0);
    padIn[5] = 1'b0;
    waitCycles(2);
    checkOutput("irq 2 edges after fall", 32'(irqO), 32'd0);
    waitCycles(1);
    checkOutput("irq 3 edges after fall", 32'(irqO), 32'(IRQ_ON));
    readReg(8'h10, "IRQ_STAT fall", IRQ_ON ? 32'h0000_0020 : 32'h0);
    writeReg(8'h10, 4'hF, 32'h0000_0020);
    checkOutput("irq after W1C", 32'(irqO), 32'd0);
    readReg(8'h10, "IRQ_STAT cleared", 32'h0);

    // Clear and set of pad 2 on the same edge: set wins.
    writeReg(8'h0C, 4'hF, 32'h0000_0024);
    padIn[2] = 1'b1;
    waitCycles(5);
    readReg(8'h10, "IRQ_STAT rise pad2", IRQ_ON ? 32'h0000_0004 : 32'h0);
    padIn[2] = 1'b0;
    waitCycles(5);
    padIn[2] = 1'b1;
    waitCycles(2);
    writeReg(8'h10, 4'hF, 32'h0000_0004);
    checkOutput("irq set beats W1C", 32'(irqO), 32'(IRQ_ON));
    readReg(8'h10, "IRQ_STAT set beats W1C", IRQ_ON ? 32'h0000_0004 : 32'h0);

    // Window boundaries.
    busXfer(1'b0, 32'h3000_0100, 4'hF, 32'h0, rd, lat);
    checkOutput("outside window no ack", 32'(lat), 32'd0);
    readReg(8'h40, "unmapped offset", 32'h0);

    // Randomized phase.
    for (int c = 0; c < 4000; c++) begin
      applyStimulus();
    end
    rst = 1'b0; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    waitCycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", nVectors, nFail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
